// File: rtl/iic_busdet_module.sv
// IIC bus front end: synchronises and filters SCL/SDA, detects START/repeated START/STOP, captures bytes.
// Also detects the soft-reset command. Define IIC_BUSDET_TIMEOUT_EN to build the SCL-low bus timeout.
module iic_busdet_module #(
  parameter int               SYNC_STG   = 2,
  parameter int               FILT_LEN   = 3,
  parameter int               CMD_W      = 8,
  parameter logic [CMD_W-1:0] SWRST_CODE = {CMD_W{1'b1}},
  parameter int               SWRST_LEN  = 4,
  parameter int               TO_CYC     = 4096
) (
  input  logic                         iic_clk,
  input  logic                         iic_rst,
  input  logic                         scl_in,
  input  logic                         sda_in,
  input  logic                         ee_wbusy_comb,
  output logic                         iic_scl_f,
  output logic                         iic_sda_f,
  output logic                         iic_start_pulse,
  output logic                         iic_rstart_pulse,
  output logic                         iic_stop_pulse,
  output logic                         iic_valid,
  output logic [$clog2(CMD_W+1)-1:0]   iic_bitcnt,
  output logic [CMD_W-1:0]             iic_byte,
  output logic                         iic_byte_vld,
  output logic                         iic_ack_bit,
  output logic                         iic_sw_rst_n,
  output logic                         iic_timeout
);

  localparam int BC_W = $clog2(CMD_W + 1);
  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int SW_W = (SWRST_LEN > 1) ? $clog2(SWRST_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SWRST  = 2'd2
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0]                pin_s;
  logic [1:0][SYNC_STG-1:0]  sync_r;
  logic [1:0][FC_W-1:0]      filt_cnt_r;
  logic [1:0]                filt_r;
  logic [1:0]                filt_d_r;

  logic                      start_s;
  logic                      stop_s;
  logic                      sample_s;
  logic                      timeout_s;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [SW_W-1:0]           swrst_cnt_r;
  logic                      swrst_done_s;
  logic                      start_acc_s;
  logic                      rstart_s;

  logic [BC_W-1:0]           bitcnt_r;
  logic [CMD_W-1:0]          shreg_r;
  logic [CMD_W:0]            sh_ext_s;
  logic [CMD_W-1:0]          byte_r;
  logic                      byte_vld_r;
  logic                      ack_r;
  logic                      first_r;
  logic                      arm_r;

  logic                      start_pulse_r;
  logic                      rstart_pulse_r;
  logic                      stop_pulse_r;
  logic                      valid_r;
  logic                      sw_rst_n_r;

  assign pin_s = {sda_in, scl_in};

  // Synchroniser chains followed by per-line stability filters
  always_ff @(posedge iic_clk) begin
    if (iic_rst) begin
      sync_r     <= {2{{SYNC_STG{1'b1}}}};
      filt_cnt_r <= {2{{FC_W{1'b0}}}};
      filt_r     <= 2'b11;
      filt_d_r   <= 2'b11;
    end else begin
      filt_d_r <= filt_r;
      for (int i = 0; i < 2; i++) begin
        sync_r[i] <= {sync_r[i][SYNC_STG-2:0], pin_s[i]};
        if (sync_r[i][SYNC_STG-1] == filt_r[i]) begin
          filt_cnt_r[i] <= {FC_W{1'b0}};
        end else if (filt_cnt_r[i] == FC_W'(FILT_LEN - 1)) begin
          filt_cnt_r[i] <= {FC_W{1'b0}};
          filt_r[i]     <= sync_r[i][SYNC_STG-1];
        end else begin
          filt_cnt_r[i] <= filt_cnt_r[i] + FC_W'(1);
        end
      end
    end
  end

  // SCL must be high in both cycles, so a simultaneous SCL/SDA change never qualifies.
  assign start_s  = filt_r[0] & filt_d_r[0] & filt_d_r[1] & ~filt_r[1];
  assign stop_s   = filt_r[0] & filt_d_r[0] & ~filt_d_r[1] & filt_r[1];
  assign sample_s = filt_r[0] & ~filt_d_r[0];

  assign swrst_done_s = (swrst_cnt_r == SW_W'(SWRST_LEN - 1));
  assign sh_ext_s     = {shreg_r, filt_r[1]};

`ifdef IIC_BUSDET_TIMEOUT_EN
  localparam int TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_r;

  assign timeout_s = valid_r & ~filt_r[0] & (to_cnt_r == TO_W'(TO_CYC - 1));

  // SCL-low watchdog, only running while a frame is open
  always_ff @(posedge iic_clk) begin
    if (iic_rst) begin
      to_cnt_r  <= {TO_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_s;
      if (!valid_r || filt_r[0] || timeout_s) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end

  assign iic_timeout = timeout_r;
`else
  assign timeout_s   = 1'b0;
  assign iic_timeout = 1'b0 & (TO_CYC > 0);
`endif

  // FSM state register
  always_ff @(posedge iic_clk) begin
    if (iic_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; an armed START always wins, even over a write-busy EEPROM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s && arm_r) begin
          state_nxt_s = ST_SWRST;
        end else if (start_s && !ee_wbusy_comb) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else if (start_s && arm_r) begin
          state_nxt_s = ST_SWRST;
        end else if (stop_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_SWRST: begin
        if (swrst_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SWRST;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: which START events are accepted in the current state
  always_comb begin
    start_acc_s = 1'b0;
    rstart_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        start_acc_s = start_s & ~arm_r & ~ee_wbusy_comb;
      end
      ST_ACTIVE: begin
        rstart_s = start_s & ~arm_r & ~timeout_s;
      end
      ST_SWRST: begin
        start_acc_s = 1'b0;
      end
      default: begin
        start_acc_s = 1'b0;
      end
    endcase
  end

  // Registered condition pulses, frame-valid and soft-reset outputs
  always_ff @(posedge iic_clk) begin
    if (iic_rst) begin
      start_pulse_r  <= 1'b0;
      rstart_pulse_r <= 1'b0;
      stop_pulse_r   <= 1'b0;
      valid_r        <= 1'b0;
      sw_rst_n_r     <= 1'b1;
      swrst_cnt_r    <= {SW_W{1'b0}};
    end else begin
      start_pulse_r  <= start_acc_s;
      rstart_pulse_r <= rstart_s;
      stop_pulse_r   <= stop_s;
      valid_r        <= (state_nxt_s == ST_ACTIVE);
      sw_rst_n_r     <= (state_nxt_s != ST_SWRST);
      if (state_r == ST_SWRST) begin
        swrst_cnt_r <= swrst_cnt_r + SW_W'(1);
      end else begin
        swrst_cnt_r <= {SW_W{1'b0}};
      end
    end
  end

  // Bit counter, shift register, byte capture and soft-reset arm flag
  always_ff @(posedge iic_clk) begin
    if (iic_rst) begin
      bitcnt_r   <= {BC_W{1'b0}};
      shreg_r    <= {CMD_W{1'b0}};
      byte_r     <= {CMD_W{1'b0}};
      byte_vld_r <= 1'b0;
      ack_r      <= 1'b0;
      first_r    <= 1'b0;
      arm_r      <= 1'b0;
    end else begin
      byte_vld_r <= 1'b0;
      if (state_nxt_s == ST_SWRST && state_r != ST_SWRST) begin
        arm_r <= 1'b0;
      end else begin
        arm_r <= arm_r;
      end
      if (state_nxt_s != ST_ACTIVE) begin
        bitcnt_r <= {BC_W{1'b0}};
      end else if (start_acc_s || rstart_s) begin
        // A partial byte in flight is simply dropped here.
        bitcnt_r <= {BC_W{1'b0}};
        first_r  <= 1'b1;
      end else if (state_r == ST_ACTIVE && sample_s) begin
        if (bitcnt_r == BC_W'(CMD_W)) begin
          bitcnt_r   <= {BC_W{1'b0}};
          byte_r     <= shreg_r;
          ack_r      <= filt_r[1];
          byte_vld_r <= 1'b1;
          first_r    <= 1'b0;
          arm_r      <= first_r & (shreg_r == SWRST_CODE) & filt_r[1];
        end else begin
          bitcnt_r <= bitcnt_r + BC_W'(1);
          shreg_r  <= sh_ext_s[CMD_W-1:0];
        end
      end else begin
        bitcnt_r <= bitcnt_r;
      end
    end
  end

  assign iic_scl_f        = filt_r[0];
  assign iic_sda_f        = filt_r[1];
  assign iic_start_pulse  = start_pulse_r;
  assign iic_rstart_pulse = rstart_pulse_r;
  assign iic_stop_pulse   = stop_pulse_r;
  assign iic_valid        = valid_r;
  assign iic_bitcnt       = bitcnt_r;
  assign iic_byte         = byte_r;
  assign iic_byte_vld     = byte_vld_r;
  assign iic_ack_bit      = ack_r;
  assign iic_sw_rst_n     = sw_rst_n_r;

endmodule

// File: tb/tb_iic_busdet_module.sv
// Self-checking bench for iic_busdet_module: pulse events go through an expected-event scoreboard.
// Define IIC_BUSDET_TIMEOUT_EN for both files to exercise the bus timeout.
module tb_iic_busdet_module;

  localparam int PH = 8;
  localparam int EV_START = 1, EV_RSTART = 2, EV_STOP = 3, EV_BYTE = 4, EV_TOUT = 5, EV_SWRST = 6;

  logic       iic_clk = 1'b0;
  logic       iic_rst = 1'b1;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
  logic       ee_wbusy_comb = 1'b0;
  logic       iic_scl_f, iic_sda_f, iic_start_pulse, iic_rstart_pulse, iic_stop_pulse;
  logic       iic_valid, iic_byte_vld, iic_ack_bit, iic_sw_rst_n, iic_timeout;
  logic [3:0] iic_bitcnt;
  logic [7:0] iic_byte;

  typedef struct { int kind; int data; } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start_cyc = -1;
  int sw_low = 0;

  iic_busdet_module #(.SYNC_STG(2), .FILT_LEN(3), .CMD_W(8), .SWRST_LEN(4), .TO_CYC(64)) dut (
    .iic_clk(iic_clk), .iic_rst(iic_rst), .scl_in(scl_in), .sda_in(sda_in),
    .ee_wbusy_comb(ee_wbusy_comb), .iic_scl_f(iic_scl_f), .iic_sda_f(iic_sda_f),
    .iic_start_pulse(iic_start_pulse), .iic_rstart_pulse(iic_rstart_pulse),
    .iic_stop_pulse(iic_stop_pulse), .iic_valid(iic_valid), .iic_bitcnt(iic_bitcnt),
    .iic_byte(iic_byte), .iic_byte_vld(iic_byte_vld), .iic_ack_bit(iic_ack_bit),
    .iic_sw_rst_n(iic_sw_rst_n), .iic_timeout(iic_timeout)
  );

  always #5 iic_clk = ~iic_clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "global timeout");
  end

  function automatic void expect_ev(input int kind, input int data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // One clock; sample outputs 1 time unit after the edge and score any pulse events.
  task automatic step();
    int   okind[6];
    int   odata[6];
    int   n;
    ev_t  e;
    @(posedge iic_clk);
    #1;
    cyc++;
    n = 0;
    if (iic_start_pulse)  begin okind[n] = EV_START;  odata[n] = 0; n++; last_start_cyc = cyc; end
    if (iic_rstart_pulse) begin okind[n] = EV_RSTART; odata[n] = 0; n++; end
    if (iic_stop_pulse)   begin okind[n] = EV_STOP;   odata[n] = 0; n++; end
    if (iic_byte_vld)     begin okind[n] = EV_BYTE;   odata[n] = int'({iic_ack_bit, iic_byte}); n++; end
    if (iic_timeout)      begin okind[n] = EV_TOUT;   odata[n] = 0; n++; end
    if (!iic_sw_rst_n) begin
      sw_low++;
    end else if (sw_low > 0) begin
      okind[n] = EV_SWRST; odata[n] = sw_low; n++;
      sw_low = 0;
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: cycle %0d got event %0d data 0x%0h, expected none", cyc, okind[i], odata[i]);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== okind[i] || e.data !== odata[i]) begin
          errors++;
          $display("FAIL sb_event: cycle %0d got event %0d data 0x%0h, expected event %0d data 0x%0h",
                   cyc, okind[i], odata[i], e.kind, e.data);
        end
      end
    end
  endtask

  task automatic drv(input logic scl, input logic sda, input int n);
    scl_in = scl;
    sda_in = sda;
    repeat (n) step();
  endtask

  task automatic bus_start();      drv(1'b1, 1'b0, PH); endtask
  task automatic bus_bit(input logic b);
    drv(1'b0, sda_in, PH);
    drv(1'b0, b, PH);
    drv(1'b1, b, PH);
  endtask
  task automatic bus_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    bus_bit(ack);
  endtask
  task automatic bus_stop();
    drv(1'b0, sda_in, PH); drv(1'b0, 1'b0, PH); drv(1'b1, 1'b0, PH); drv(1'b1, 1'b1, PH);
  endtask
  task automatic bus_rstart();
    drv(1'b0, sda_in, PH); drv(1'b0, 1'b1, PH); drv(1'b1, 1'b1, PH); drv(1'b1, 1'b0, PH);
  endtask

  task automatic test_reset();
    iic_rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({iic_scl_f, iic_sda_f, iic_sw_rst_n, iic_valid, iic_start_pulse, iic_rstart_pulse,
         iic_stop_pulse, iic_byte_vld, iic_ack_bit, iic_timeout} !== 10'b1110000000) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 1110000000", {iic_scl_f, iic_sda_f, iic_sw_rst_n,
               iic_valid, iic_start_pulse, iic_rstart_pulse, iic_stop_pulse, iic_byte_vld, iic_ack_bit, iic_timeout});
    end
    checks++;
    if (iic_bitcnt !== 4'd0 || iic_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: bitcnt %0d byte 0x%0h, expected 0 and 0x00", iic_bitcnt, iic_byte);
    end
    iic_rst = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_start();
    int t0;
    expect_ev(EV_START, 0);
    t0 = cyc;
    bus_start();
    checks++;
    if (last_start_cyc - t0 != 6) begin
      errors++;
      $display("FAIL start_latency: got %0d cycles, expected 6", last_start_cyc - t0);
    end
    checks++;
    if (iic_valid !== 1'b1 || iic_bitcnt !== 4'd0) begin
      errors++;
      $display("FAIL start_state: valid %b bitcnt %0d, expected 1 and 0", iic_valid, iic_bitcnt);
    end
  endtask

  task automatic test_byte();
    logic [7:0] b;
    b = 8'hA5;
    expect_ev(EV_BYTE, 'h0A5);
    for (int i = 7; i >= 0; i--) begin
      bus_bit(b[i]);
      if (i == 5) begin
        checks++;
        if (iic_bitcnt !== 4'd3) begin
          errors++;
          $display("FAIL byte_midcount: got %0d, expected 3", iic_bitcnt);
        end
      end
    end
    bus_bit(1'b0);
    checks++;
    if (iic_byte !== 8'hA5 || iic_ack_bit !== 1'b0 || iic_bitcnt !== 4'd0) begin
      errors++;
      $display("FAIL byte_a5: byte 0x%0h ack %b bitcnt %0d, expected 0xa5 0 0", iic_byte, iic_ack_bit, iic_bitcnt);
    end
    expect_ev(EV_STOP, 0);
    bus_stop();
    checks++;
    if (iic_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_valid: got %b, expected 0", iic_valid);
    end
  endtask

  task automatic test_busy();
    ee_wbusy_comb = 1'b1;
    drv(1'b1, 1'b0, PH);
    checks++;
    if (iic_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_valid: got %b, expected 0", iic_valid);
    end
    expect_ev(EV_STOP, 0);
    drv(1'b1, 1'b1, PH);
    ee_wbusy_comb = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_pending: %0d events outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_swrst();
    int n;
    expect_ev(EV_START, 0);
    bus_start();
    expect_ev(EV_BYTE, 'h1FF);
    bus_byte(8'hFF, 1'b1);
    expect_ev(EV_SWRST, 4);
    bus_rstart();
    n = 0;
    while (iic_sw_rst_n === 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL swrst_wait: sw_rst_n low not seen within 20 cycles, expected low");
    end else if (iic_valid !== 1'b0) begin
      errors++;
      $display("FAIL swrst_valid: got %b during soft reset, expected 0", iic_valid);
    end
    repeat (PH) step();
    expect_ev(EV_STOP, 0);
    bus_stop();
    // Armed, then STOP, then START from idle with the EEPROM busy.
    expect_ev(EV_START, 0);
    bus_start();
    expect_ev(EV_BYTE, 'h1FF);
    bus_byte(8'hFF, 1'b1);
    expect_ev(EV_STOP, 0);
    bus_stop();
    ee_wbusy_comb = 1'b1;
    expect_ev(EV_SWRST, 4);
    drv(1'b1, 1'b0, 2 * PH);
    ee_wbusy_comb = 1'b0;
    expect_ev(EV_STOP, 0);
    drv(1'b1, 1'b1, PH);
    checks++;
    if (iic_sw_rst_n !== 1'b1 || iic_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL swrst_end: sw_rst_n %b valid %b pending %0d, expected 1 0 0", iic_sw_rst_n, iic_valid, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    drv(1'b1, 1'b0, 2);
    scl_in = 1'b1;
    sda_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (iic_sda_f !== 1'b1) begin
        errors++;
        $display("FAIL glitch_short: sda_f %b at cycle %0d, expected 1", iic_sda_f, i);
      end
    end
    expect_ev(EV_START, 0);
    expect_ev(EV_STOP, 0);
    drv(1'b1, 1'b0, 3);
    drv(1'b1, 1'b1, 12);
    checks++;
    if (iic_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_long: valid %b pending %0d, expected 0 0", iic_valid, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    expect_ev(EV_START, 0);
    bus_start();
    bus_bit(1'b1);
    bus_bit(1'b0);
    bus_bit(1'b1);
`ifdef IIC_BUSDET_TIMEOUT_EN
    expect_ev(EV_TOUT, 0);
    drv(1'b0, sda_in, 80);
    checks++;
    if (iic_valid !== 1'b0 || iic_bitcnt !== 4'd0) begin
      errors++;
      $display("FAIL timeout_state: valid %b bitcnt %0d, expected 0 0", iic_valid, iic_bitcnt);
    end
`else
    drv(1'b0, sda_in, 80);
    checks++;
    if (iic_valid !== 1'b1 || iic_bitcnt !== 4'd3) begin
      errors++;
      $display("FAIL no_timeout_state: valid %b bitcnt %0d, expected 1 3", iic_valid, iic_bitcnt);
    end
`endif
    expect_ev(EV_STOP, 0);
    bus_stop();
    checks++;
    if (iic_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_end: valid %b pending %0d, expected 0 0", iic_valid, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midframe();
    expect_ev(EV_START, 0);
    bus_start();
    bus_bit(1'b1);
    bus_bit(1'b1);
    bus_bit(1'b0);
    bus_bit(1'b0);
    scl_in = 1'b0;
    iic_rst = 1'b1;
    step();
    checks++;
    if ({iic_scl_f, iic_sda_f, iic_sw_rst_n, iic_valid, iic_start_pulse, iic_rstart_pulse,
         iic_stop_pulse, iic_byte_vld, iic_ack_bit, iic_timeout} !== 10'b1110000000) begin
      errors++;
      $display("FAIL midreset_flags: got %b, expected 1110000000", {iic_scl_f, iic_sda_f, iic_sw_rst_n,
               iic_valid, iic_start_pulse, iic_rstart_pulse, iic_stop_pulse, iic_byte_vld, iic_ack_bit, iic_timeout});
    end
    checks++;
    if (iic_bitcnt !== 4'd0 || iic_byte !== 8'h00) begin
      errors++;
      $display("FAIL midreset_data: bitcnt %0d byte 0x%0h, expected 0 and 0x00", iic_bitcnt, iic_byte);
    end
    iic_rst = 1'b0;
    drv(1'b0, 1'b0, 10);
    drv(1'b0, 1'b1, PH);
    drv(1'b1, 1'b1, PH);
    checks++;
    if (iic_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_end: valid %b pending %0d, expected 0 0", iic_valid, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_byte();
    test_busy();
    test_swrst();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iic_busdet_module.md
Name: iic_busdet_module

Overview:
- Parametrised successor to the IIC start/valid/soft-reset detector: one oversampling clock domain, no pin-derived clocks.
- Synchronises and glitch-filters SCL/SDA, then detects START, repeated START and STOP.
- Counts bits and captures bytes; detects the soft-reset command sequence.
- Sits between the pad inputs and the IIC slave FSM, and gates new frames while the EEPROM is write-busy.

Parameters:
- SYNC_STG, 2: synchroniser flops per line (>=2).
- FILT_LEN, 3: consecutive stable samples required before a filtered line changes (>=1).
- CMD_W, 8: bits per byte before the ACK slot.
- SWRST_CODE, all ones (CMD_W bits): byte value that arms soft reset.
- SWRST_LEN, 4: cycles that iic_sw_rst_n is held low (>=1).
- TO_CYC, 4096: SCL-low timeout in clocks (used only with the optional feature).

Ports:
- iic_clk, in, 1: oversampling clock, at least 8x SCL.
- iic_rst, in, 1: synchronous, active-high reset.
- scl_in, in, 1: raw SCL pad input.
- sda_in, in, 1: raw SDA pad input.
- ee_wbusy_comb, in, 1: EEPROM write in progress; new frames are rejected while high.
- iic_scl_f, out, 1: filtered SCL.
- iic_sda_f, out, 1: filtered SDA.
- iic_start_pulse, out, 1: 1-cycle pulse on an accepted START from idle.
- iic_rstart_pulse, out, 1: 1-cycle pulse on an accepted repeated START.
- iic_stop_pulse, out, 1: 1-cycle pulse on STOP.
- iic_valid, out, 1: frame active.
- iic_bitcnt, out, clog2(CMD_W+1): bit index within the current byte.
- iic_byte, out, CMD_W: last captured byte, MSB first.
- iic_byte_vld, out, 1: 1-cycle pulse when a byte plus its ACK slot completes.
- iic_ack_bit, out, 1: SDA value sampled in the ACK slot; 1 = NACK.
- iic_sw_rst_n, out, 1: active-low soft-reset pulse.
- iic_timeout, out, 1: 1-cycle pulse on bus timeout; tied 0 when the optional feature is off.

Behaviour:
- Reset values: iic_scl_f=1, iic_sda_f=1, iic_sw_rst_n=1, iic_valid=0, iic_bitcnt=0, iic_byte=0, iic_ack_bit=0, all pulses 0, FSM=IDLE, arm flag 0, counters 0. Reset is synchronous and overrides all other events in the same cycle.
- Filter:
  - Each line passes through SYNC_STG flops, then a stability counter.
  - The filtered value updates only after FILT_LEN consecutive samples differ from the current filtered value; any matching sample clears the counter.
  - Pin-to-filtered latency is SYNC_STG+FILT_LEN cycles.
- Condition detection uses the filtered lines and their 1-cycle-old copies:
  - START: SCL high in both cycles and SDA 1->0.
  - STOP: SCL high in both cycles and SDA 1->0 reversed, i.e. SDA 0->1.
  - Data sample: SCL 0->1.
  - If SCL and SDA change in the same cycle, no START or STOP is flagged.
- Pulses are registered and assert 1 cycle after the detecting edge.
- FSM states: IDLE, ACTIVE, SWRST.
  - IDLE, START, ee_wbusy_comb=0: go to ACTIVE; pulse iic_start_pulse; set iic_valid=1; clear iic_bitcnt.
  - IDLE, START, ee_wbusy_comb=1: ignored; no pulse; remain in IDLE.
  - ACTIVE, START, arm flag=1: go to SWRST.
  - ACTIVE, START, arm flag=0: pulse iic_rstart_pulse; clear iic_bitcnt; iic_valid stays 1.
  - ACTIVE, STOP: go to IDLE; iic_valid=0.
  - iic_stop_pulse fires on any STOP, in any state.
  - SWRST: drive iic_sw_rst_n=0 for exactly SWRST_LEN cycles with iic_valid=0, then go to IDLE. START/STOP detected during SWRST are dropped, but the filters keep running.
- Bit handling in ACTIVE, on each data sample:
  - iic_bitcnt < CMD_W: shift SDA into the shift register, increment the count.
  - iic_bitcnt == CMD_W: latch the ACK bit, copy the shift register to iic_byte, pulse iic_byte_vld, wrap the count to 0.
  - Data samples in IDLE are ignored.
- Arm flag:
  - Set on iic_byte_vld when the byte is the first byte after a START or repeated START, iic_byte == SWRST_CODE, and iic_ack_bit == 1.
  - Cleared by any other completed byte, by entering SWRST, and by reset.
  - STOP does not clear it: a STOP followed by a START from IDLE with the arm flag set also goes to SWRST, even when ee_wbusy_comb=1.
- START arriving while iic_bitcnt != 0: the partial byte is discarded and no iic_byte_vld is generated.

Optional Feature:
- Macro: IIC_BUSDET_TIMEOUT_EN.
- When defined: a counter runs while iic_valid=1 and iic_scl_f=0, and clears whenever SCL is high. At count TO_CYC-1 the block pulses iic_timeout for 1 cycle, forces IDLE, and sets iic_valid=0 and iic_bitcnt=0.
- When undefined: no counter is built, iic_timeout is tied 0, and SCL may be held low indefinitely.

Test Plan:
- Reset then a clean START with ee_wbusy_comb=0 -> iic_start_pulse at SYNC_STG+FILT_LEN+1 cycles after the SDA fall, iic_valid=1, iic_bitcnt=0.
- Byte 0xA5 followed by ACK=0 -> iic_byte_vld pulse, iic_byte=0xA5, iic_ack_bit=0, iic_bitcnt returns to 0.
- START with ee_wbusy_comb=1 -> no start pulse; iic_valid stays 0; a following STOP still pulses iic_stop_pulse.
- START, byte 0xFF with NACK, then repeated START -> iic_sw_rst_n low for exactly 4 cycles, iic_valid=0, no iic_rstart_pulse.
- SDA glitch of FILT_LEN-1 cycles while SCL is high -> no START, iic_sda_f unchanged; a glitch of FILT_LEN cycles -> START detected.
- With IIC_BUSDET_TIMEOUT_EN defined and TO_CYC=64, SCL held low for 64 cycles mid-byte -> iic_timeout pulse, iic_valid=0; assert iic_rst mid-frame -> all outputs return to reset values on the next edge.
